// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and the raster segment type used by the
// timing generator and the pixel renderer.
package vga_pkg;

    typedef enum logic [1:0] {
        SEG_ACTIVE = 2'd0,
        SEG_FP     = 2'd1,
        SEG_SYNC   = 2'd2,
        SEG_BP     = 2'd3
    } seg_e;

    // 640x480@60 (25.175 MHz pixel clock, negative syncs)
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam bit VGA640_HS_POL   = 1'b0;
    localparam bit VGA640_VS_POL   = 1'b0;

    // 800x600@60 (40 MHz pixel clock, positive syncs)
    localparam int VGA800_H_ACTIVE = 800;
    localparam int VGA800_H_FP     = 40;
    localparam int VGA800_H_SYNC   = 128;
    localparam int VGA800_H_BP     = 88;
    localparam int VGA800_V_ACTIVE = 600;
    localparam int VGA800_V_FP     = 1;
    localparam int VGA800_V_SYNC   = 4;
    localparam int VGA800_V_BP     = 23;
    localparam bit VGA800_HS_POL   = 1'b1;
    localparam bit VGA800_VS_POL   = 1'b1;

    function automatic seg_e seg_of(input int pos, input int active,
                                    input int fp, input int sync);
        if (pos < active) begin
            return SEG_ACTIVE;
        end else if (pos < active + fp) begin
            return SEG_FP;
        end else if (pos < active + fp + sync) begin
            return SEG_SYNC;
        end else begin
            return SEG_BP;
        end
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered active and
// sync decodes that change on the same edge as the count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int TOTAL  = ACTIVE + FP + SYNC + BP,
    parameter int W      = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         in_active,
    output logic         sync
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] count_next;
    seg_e         seg_next;

    // Next position and the segment it falls in, so decodes track the count.
    always_comb begin
        if (count == LAST) begin
            count_next = '0;
        end else begin
            count_next = count + W'(1);
        end
        seg_next = seg_of(int'(count_next), ACTIVE, FP, SYNC);
    end

    assign wrap = (count == LAST);

    // Position and decode registers; reset position 0 lies in the active segment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            in_active <= 1'b1;
            sync      <= ~POL;
        end else if (inc) begin
            count     <= count_next;
            in_active <= (seg_next == SEG_ACTIVE);
            sync      <= (seg_next == SEG_SYNC) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel prescaler, h/v axis counters, line and
// frame strobes and a once-per-N-frames tick.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV         = 2,
    parameter int H_ACTIVE        = VGA640_H_ACTIVE,
    parameter int H_FP            = VGA640_H_FP,
    parameter int H_SYNC          = VGA640_H_SYNC,
    parameter int H_BP            = VGA640_H_BP,
    parameter int V_ACTIVE        = VGA640_V_ACTIVE,
    parameter int V_FP            = VGA640_V_FP,
    parameter int V_SYNC          = VGA640_V_SYNC,
    parameter int V_BP            = VGA640_V_BP,
    parameter bit HS_POL          = VGA640_HS_POL,
    parameter bit VS_POL          = VGA640_VS_POL,
    parameter int FRAMES_PER_TICK = 60,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_ce,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start,
    output logic          tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [FW-1:0] F_LAST   = FW'(FRAMES_PER_TICK - 1);

    logic [PW-1:0] pre;
    logic [FW-1:0] fcnt, f_next;
    logic ce_r, ls_r, fs_r, tk_r;
    logic h_wrap, v_wrap, h_act, v_act;
    logic adv, v_inc, f_inc, ce_d;
    logic h_last_after, v_last_after;

    // Look one edge ahead: strobes must coincide with the pixel whose
    // position is terminal, which matters when pixels advance every clock.
    always_comb begin
        adv   = en & ce_r;
        v_inc = adv & h_wrap;
        f_inc = v_inc & v_wrap;
        ce_d  = (pre == PRE_LAST);
        if (adv) begin
            h_last_after = (x == XW'(H_TOTAL - 2));
        end else begin
            h_last_after = h_wrap;
        end
        if (v_inc) begin
            v_last_after = (y == YW'(V_TOTAL - 2));
        end else begin
            v_last_after = v_wrap;
        end
        if (f_inc) begin
            if (fcnt == F_LAST) begin
                f_next = '0;
            end else begin
                f_next = fcnt + FW'(1);
            end
        end else begin
            f_next = fcnt;
        end
    end

    // Prescaler, frame counter and strobe registers; all hold while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre  <= '0;
            fcnt <= '0;
            ce_r <= 1'b0;
            ls_r <= 1'b0;
            fs_r <= 1'b0;
            tk_r <= 1'b0;
        end else if (en) begin
            pre  <= ce_d ? '0 : pre + PW'(1);
            fcnt <= f_next;
            ce_r <= ce_d;
            ls_r <= ce_d & h_last_after;
            fs_r <= ce_d & h_last_after & v_last_after;
            tk_r <= ce_d & h_last_after & v_last_after & (f_next == F_LAST);
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL)
    ) u_h (
        .clk       (clk),
        .rst       (rst),
        .inc       (adv),
        .count     (x),
        .wrap      (h_wrap),
        .in_active (h_act),
        .sync      (hsync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL)
    ) u_v (
        .clk       (clk),
        .rst       (rst),
        .inc       (v_inc),
        .count     (y),
        .wrap      (v_wrap),
        .in_active (v_act),
        .sync      (vsync)
    );

    // A frozen generator must not emit pulses, so strobes are masked by en.
    assign pix_ce      = ce_r & en;
    assign line_start  = ls_r & en;
    assign frame_start = fs_r & en;
    assign tick        = tk_r & en;
    assign active      = h_act & v_act;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two configurations driven by a shared clock,
// reset and randomized enable, compared every cycle with a raster model.
module tb_vga_timing_gen;

    localparam int HA = 8, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 4, VFP = 1, VSY = 2, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;

    typedef struct packed {
        bit ce;
        int x;
        int y;
        bit act;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
        bit tk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   t = 0;
    bit   run_chk = 1'b0;

    logic       ce_a, act_a, hs_a, vs_a, ls_a, fs_a, tk_a;
    logic [3:0] x_a;
    logic [2:0] y_a;
    logic       ce_b, act_b, hs_b, vs_b, ls_b, fs_b, tk_b;
    logic [3:0] x_b;
    logic [2:0] y_b;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .FRAMES_PER_TICK(3)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .pix_ce(ce_a), .x(x_a), .y(y_a),
        .active(act_a), .hsync(hs_a), .vsync(vs_a), .line_start(ls_a),
        .frame_start(fs_a), .tick(tk_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .FRAMES_PER_TICK(2)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .pix_ce(ce_b), .x(x_b), .y(y_b),
        .active(act_b), .hsync(hs_b), .vsync(vs_b), .line_start(ls_b),
        .frame_start(fs_b), .tick(tk_b)
    );

    // Raster model: after tt enabled clocks, pixel p=(tt-1)/d is on screen;
    // a pixel pulse ends every d-th enabled clock.
    function automatic exp_t model(input int tt, input logic en_v, input int d,
                                   input int f, input bit pol);
        exp_t e;
        int   p;
        p     = (tt == 0) ? 0 : (tt - 1) / d;
        e.x   = p % HT;
        e.y   = (p / HT) % VT;
        e.ce  = (en_v === 1'b1) && (tt >= 1) && ((tt % d) == 0);
        e.ls  = e.ce && (e.x == HT - 1);
        e.fs  = e.ls && (e.y == VT - 1);
        e.tk  = e.fs && (((p / (HT * VT)) % f) == f - 1);
        e.act = (e.x < HA) && (e.y < VA);
        e.hs  = (e.x >= HA + HFP && e.x < HA + HFP + HSY) ? pol : ~pol;
        e.vs  = (e.y >= VA + VFP && e.y < VA + VFP + VSY) ? pol : ~pol;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", name, act, exp, t, $time);
        end
    endtask

    // Enabled-clock counter that drives the model.
    always @(posedge clk or posedge rst) begin
        if (rst) t <= 0;
        else if (en) t <= t + 1;
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        exp_t ea, eb;
        if (run_chk) begin
            ea = model(t, en, 2, 3, 1'b0);
            eb = model(t, en, 1, 2, 1'b1);
            chk("A.pix_ce", 32'(ce_a), 32'(ea.ce));
            chk("A.x", 32'(x_a), 32'(ea.x));
            chk("A.y", 32'(y_a), 32'(ea.y));
            chk("A.active", 32'(act_a), 32'(ea.act));
            chk("A.hsync", 32'(hs_a), 32'(ea.hs));
            chk("A.vsync", 32'(vs_a), 32'(ea.vs));
            chk("A.line_start", 32'(ls_a), 32'(ea.ls));
            chk("A.frame_start", 32'(fs_a), 32'(ea.fs));
            chk("A.tick", 32'(tk_a), 32'(ea.tk));
            chk("B.pix_ce", 32'(ce_b), 32'(eb.ce));
            chk("B.x", 32'(x_b), 32'(eb.x));
            chk("B.y", 32'(y_b), 32'(eb.y));
            chk("B.active", 32'(act_b), 32'(eb.act));
            chk("B.hsync", 32'(hs_b), 32'(eb.hs));
            chk("B.vsync", 32'(vs_b), 32'(eb.vs));
            chk("B.line_start", 32'(ls_b), 32'(eb.ls));
            chk("B.frame_start", 32'(fs_b), 32'(eb.fs));
            chk("B.tick", 32'(tk_b), 32'(eb.tk));
        end
    end

    initial begin
        int n, first_ls, first_fs, first_tk, first_ls_b, second_tk, found;

        repeat (2) @(posedge clk);
        #2;
        chk("reset.A.x", 32'(x_a), 32'd0);
        chk("reset.A.y", 32'(y_a), 32'd0);
        chk("reset.A.active", 32'(act_a), 32'd1);
        chk("reset.A.hsync", 32'(hs_a), 32'd1);
        chk("reset.A.vsync", 32'(vs_a), 32'd1);
        chk("reset.B.hsync", 32'(hs_b), 32'd0);
        chk("reset.B.vsync", 32'(vs_b), 32'd0);
        chk("reset.A.pix_ce", 32'(ce_a), 32'd0);
        run_chk = 1'b1;
        rst = 1'b0;
        en  = 1'b1;

        // Strobe cadence from reset release, counted in clocks.
        first_ls = -1; first_fs = -1; first_tk = -1; first_ls_b = -1; second_tk = -1;
        for (int i = 1; i <= 1600; i++) begin
            @(posedge clk);
            #1;
            if (ls_b && first_ls_b < 0) first_ls_b = i;
            if (ls_a && first_ls < 0) first_ls = i;
            if (fs_a && first_fs < 0) first_fs = i;
            if (tk_a && first_tk < 0) first_tk = i;
            else if (tk_a && second_tk < 0) second_tk = i;
            if (second_tk >= 0) break;
        end
        chk("first_line_start_A", 32'(first_ls), 32'd32);
        chk("first_frame_start_A", 32'(first_fs), 32'd256);
        chk("first_tick_A", 32'(first_tk), 32'd768);
        chk("second_tick_A", 32'(second_tk), 32'd1536);
        chk("first_line_start_B", 32'(first_ls_b), 32'd16);

        // Freeze at x=5, y=2 for 50 clocks.
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (x_a == 4'd5 && y_a == 3'd2) begin
                found = 1;
                break;
            end
        end
        chk("freeze_reach", 32'(found), 32'd1);
        #1 en = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("freeze.A.x", 32'(x_a), 32'd5);
        chk("freeze.A.y", 32'(y_a), 32'd2);
        chk("freeze.A.pix_ce", 32'(ce_a), 32'd0);
        #1 en = 1'b1;

        // Reset pulse while inside the horizontal sync window.
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (x_a == 4'd12) begin
                found = 1;
                break;
            end
        end
        chk("rst_reach_x12", 32'(found), 32'd1);
        chk("x12.A.hsync", 32'(hs_a), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst.A.hsync", 32'(hs_a), 32'd1);
        chk("async_rst.A.x", 32'(x_a), 32'd0);
        chk("async_rst.B.hsync", 32'(hs_b), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        first_ls = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (ls_a) begin
                first_ls = i;
                break;
            end
        end
        chk("post_rst_line_start_A", 32'(first_ls), 32'd32);

        // Randomized enable with rare short reset pulses.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2;
            en = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        en = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        run_chk = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: the next generation of our fixed-count sync divider, which produced approximate 31.5 kHz / 61.5 Hz sync and a ~1 Hz tick. The block divides the board clock to a pixel enable and runs horizontal and vertical counters with programmable porch and sync lengths. It drives hsync/vsync with selectable polarity, pixel coordinates, an active-video flag and line/frame strobes, plus an exact once-per-N-frames tick for the temporizer. It sits between the board clock pin and the pixel renderer / temporizer logic.

## Interface
- CLK_DIV, 2: board clocks per pixel (≥1).
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal segment lengths in pixels (each ≥1).
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical segment lengths in lines (each ≥1).
- HS_POL, 0; VS_POL, 0: sync asserted level (0 = active-low).
- FRAMES_PER_TICK, 60: frames per tick pulse (≥1).
- clk  in  1  board clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; low freezes all counters and outputs.
- pix_ce  out  1  one-clk pulse per pixel.
- x  out  clog2(H_TOTAL)  current horizontal count, 0..H_TOTAL-1.
- y  out  clog2(V_TOTAL)  current vertical count, 0..V_TOTAL-1.
- active  out  1  x<H_ACTIVE and y<V_ACTIVE.
- hsync  out  1  horizontal sync at HS_POL level while in sync window.
- vsync  out  1  vertical sync at VS_POL level while in sync window.
- line_start  out  1  one-clk pulse coincident with pix_ce when x wraps to 0.
- frame_start  out  1  one-clk pulse coincident with pix_ce when x and y both wrap to 0.
- tick  out  1  one-clk pulse on every FRAMES_PER_TICK-th frame_start.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Prescaler counts 0..CLK_DIV-1 while en; pix_ce asserted in the cycle it equals CLK_DIV-1. CLK_DIV=1: pix_ce high every enabled cycle.
- On pix_ce: x increments, wraps H_TOTAL-1 → 0; on that wrap y increments, wraps V_TOTAL-1 → 0.
- Frame counter increments on each frame wrap; at FRAMES_PER_TICK-1 it wraps to 0 and tick pulses with that frame_start.
- hsync asserted iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC; vsync iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC. Deasserted level = ~POL.
- en low: prescaler, x, y and frame counter hold; pix_ce, line_start, frame_start, tick forced 0; hsync/vsync/active hold.
- Counter widths exact clog2; no counter exceeds its terminal value; all arithmetic unsigned.

## Timing
- Reset (async assert, sync release): prescaler=0, x=0, y=0, frame count=0, pix_ce=line_start=frame_start=tick=0, active=1, hsync=~HS_POL, vsync=~VS_POL.
- hsync, vsync, active registered and updated in the same edge as x/y: zero-cycle skew between coordinates and their decodes.
- Strobes are decoded from the pre-wrap state: line_start, frame_start and tick are high in the same cycle as pix_ce, and x/y show 0 on the following cycle.
- First pix_ce after reset release arrives CLK_DIV cycles after the first enabled edge. Frame period = CLK_DIV·H_TOTAL·V_TOTAL clocks exactly.
- Reset mid-frame discards position immediately; no partial-sync glitch beyond the async deassertion.

## Structure
- Shared package vga_pkg: timing parameter defaults for 640x480@60 and 800x600@60, and an h/v segment enum (ACTIVE, FP, SYNC, BP) used by the renderer.
- One sub-module, vga_axis_counter: instantiated twice, once for h and once for v. Parametrised by the four segment lengths and polarity, and advanced by an increment enable. It outputs count, wrap, in_active and sync.

## Test plan
- Small config H=8/2/3/3, V=4/1/2/1, CLK_DIV=2, FRAMES_PER_TICK=3, en=1 → line_start every 32 clks, frame_start every 256 clks, tick every 768 clks.
- Same config → hsync low exactly while x∈{10,11,12}; vsync low exactly while y∈{5,6}; active high only for x<8, y<4.
- HS_POL=1, VS_POL=1 → sync windows inverted; reset values hsync=0, vsync=0.
- CLK_DIV=1 → pix_ce constant high; x increments every clock and wraps 15→0 with line_start.
- en low for 50 clks at x=5, y=2 → x, y and outputs frozen, no strobes; resumes at x=5 with the prescaler phase preserved.
- rst pulsed at x=12 (in hsync) → outputs take reset values immediately, asynchronously; after release the first line_start is 32 clks later.
